// File: rtl/instruction_fetch.sv
// Fetch stage: credit-limited sequential reads into a small FIFO, with
// redirect/stop flushing buffered words and squashing the in-flight read.
module instruction_fetch #(
  parameter int PC_WIDTH = 13,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  input  logic                stop,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_re,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic [15:0]         raw_instruction,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic                busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 16 + PC_WIDTH;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_re;
  logic [PC_WIDTH-1:0] r_addr;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic                r_inflight;
  logic [PC_WIDTH-1:0] r_inflight_pc;
  logic                r_inflight_epoch;
  logic                r_epoch;
  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_valid;
  logic [15:0]         r_raw;
  logic [PC_WIDTH-1:0] r_pc;

  logic                w_run, w_start, w_stop, w_redir, w_flush;
  logic                w_pop, w_ret, w_run_next, w_issue;
  logic [CW-1:0]       w_after_pop, w_count_next;
  logic [AW-1:0]       w_rd_next;
  logic [PC_WIDTH-1:0] w_pc_base;
  logic [EW-1:0]       w_ret_word, w_head_next;

  assign w_run        = (r_state == S_RUN);
  assign w_start      = ~w_run & start;
  assign w_stop       = w_run & stop;
  assign w_redir      = w_run & ~stop & redirect_valid;
  assign w_flush      = w_start | w_stop | w_redir;
  assign w_pop        = r_valid & instr_ready;
  // A return is kept only if its read was tagged with the current epoch.
  assign w_ret        = w_run & r_inflight & (r_inflight_epoch == r_epoch) & ~w_flush;
  assign w_ret_word   = {imem_data, r_inflight_pc};
  assign w_after_pop  = r_count - CW'(w_pop);
  assign w_count_next = w_flush ? '0 : (w_after_pop + CW'(w_ret));
  assign w_rd_next    = r_rd_ptr + AW'(w_pop);
  assign w_run_next   = w_start | (w_run & ~w_stop);
  assign w_pc_base    = w_start ? start_pc : (w_redir ? redirect_pc : r_fetch_pc);
  // Credits are checked against the next cycle's occupancy plus the read in flight then.
  assign w_issue      = w_run_next &
                        (((CW+1)'(w_count_next) + (CW+1)'(r_re)) < (CW+1)'(DEPTH));
  assign w_head_next  = (w_after_pop == '0) ? w_ret_word : r_mem[w_rd_next];

  always_ff @(posedge clk) begin
    if (w_ret) r_mem[r_wr_ptr] <= w_ret_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_busy           <= 1'b0;
      r_re             <= 1'b0;
      r_addr           <= '0;
      r_fetch_pc       <= '0;
      r_inflight       <= 1'b0;
      r_inflight_pc    <= '0;
      r_inflight_epoch <= 1'b0;
      r_epoch          <= 1'b0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_valid          <= 1'b0;
      r_raw            <= '0;
      r_pc             <= '0;
    end else begin
      r_state          <= w_run_next ? S_RUN : S_IDLE;
      r_busy           <= w_run_next;
      r_re             <= w_issue;
      if (w_issue) begin
        r_addr     <= w_pc_base;
        r_fetch_pc <= w_pc_base + 1'b1;
      end
      r_inflight       <= r_re & ~w_stop;
      r_inflight_pc    <= r_addr;
      r_inflight_epoch <= r_epoch;
      if (w_redir) r_epoch <= ~r_epoch;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_ret) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= w_rd_next;
      end
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      // Output head is a registered copy of the next FIFO head.
      if (!w_flush && (w_count_next != '0)) {r_raw, r_pc} <= w_head_next;
    end
  end

  assign imem_re         = r_re;
  assign imem_addr       = r_addr;
  assign raw_instruction = r_raw;
  assign instr_pc        = r_pc;
  assign instr_valid     = r_valid;
  assign busy            = r_busy;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: scoreboard of expected fetch order plus
// cycle-exact timing checks around start, stall, redirect, stop and reset.
module tb_instruction_fetch;
  localparam int PW = 13;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] start_pc = '0;
  logic          stop = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic          imem_re;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_data = '0;
  logic [15:0]   raw_instruction;
  logic [PW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] key;

  always #5 clk = ~clk;

  instruction_fetch #(.PC_WIDTH(PW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .stop(stop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_re(imem_re), .imem_addr(imem_addr), .imem_data(imem_data),
    .raw_instruction(raw_instruction), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy)
  );

  function automatic logic [15:0] word(input logic [PW-1:0] a);
    return 16'(a) ^ key;
  endfunction

  // Instruction memory: data one cycle after the strobe, junk otherwise.
  initial forever begin
    @(posedge clk);
    imem_data <= (imem_re === 1'b1) ? word(imem_addr) : 16'($urandom);
  end

  // Reference model: a running/idle flag and the next expected fetch address.
  logic          model_run = 1'b0;
  logic [PW-1:0] exp_pc = '0;
  logic          hold = 1'b0;
  logic [15:0]   h_raw;
  logic [PW-1:0] h_pc;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      model_run = 1'b0;
      hold = 1'b0;
    end else begin
      checks++;
      if (busy !== model_run) begin
        errors++; $display("FAIL busy: got %b want %b", busy, model_run);
      end
      if (!model_run) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++; $display("FAIL idle_valid: got %b want 0", instr_valid);
        end
      end
      if (hold) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== h_pc || raw_instruction !== h_raw) begin
          errors++;
          $display("FAIL head_stable: got v=%b pc=%h raw=%h want v=1 pc=%h raw=%h",
                   instr_valid, instr_pc, raw_instruction, h_pc, h_raw);
        end
      end
      if (model_run && instr_valid === 1'b1 && instr_ready) begin
        checks++;
        if (instr_pc !== exp_pc || raw_instruction !== word(exp_pc)) begin
          errors++;
          $display("FAIL order: got pc=%h raw=%h want pc=%h raw=%h",
                   instr_pc, raw_instruction, exp_pc, word(exp_pc));
        end
      end
      hold  = model_run && !stop && !redirect_valid && instr_valid === 1'b1 && !instr_ready;
      h_raw = raw_instruction;
      h_pc  = instr_pc;
      if (!model_run) begin
        if (start) begin model_run = 1'b1; exp_pc = start_pc; end
      end else if (stop) begin
        model_run = 1'b0;
      end else if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (instr_valid === 1'b1 && instr_ready) begin
        exp_pc = exp_pc + 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (imem_re !== 1'b0 || imem_addr !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_fetch: got re=%b addr=%h busy=%b want 0 0 0", imem_re, imem_addr, busy);
    end
    checks++;
    if (instr_valid !== 1'b0 || raw_instruction !== '0 || instr_pc !== '0) begin
      errors++; $display("FAIL reset_head: got v=%b raw=%h pc=%h want 0 0 0", instr_valid, raw_instruction, instr_pc);
    end
    reset = 1'b0;
    tick();
  endtask

  // Issues start in the current cycle T and checks the T+1 / T+3 timing.
  task automatic do_start(input logic [PW-1:0] pc, input string tag);
    start_pc = pc; start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (imem_re !== 1'b1 || imem_addr !== pc) begin
      errors++; $display("FAIL %s_issue: got re=%b addr=%h want 1 %h", tag, imem_re, imem_addr, pc);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL %s_early: got valid=%b want 0", tag, instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== pc || raw_instruction !== word(pc)) begin
      errors++; $display("FAIL %s_first: got v=%b pc=%h raw=%h want 1 %h %h",
                         tag, instr_valid, instr_pc, raw_instruction, pc, word(pc));
    end
  endtask

  task automatic test_start_stream();
    do_start(13'h010, "start");
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1) begin
        errors++; $display("FAIL throughput: cycle %0d got valid=%b want 1", i, instr_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [PW-1:0] diff;
    instr_ready = 1'b0;
    repeat (10) tick();
    diff = imem_addr - instr_pc;
    checks++;
    if (imem_re !== 1'b0 || instr_valid !== 1'b1 || diff !== PW'(D - 1)) begin
      errors++; $display("FAIL stall_fill: got re=%b v=%b issued_ahead=%0d want 0 1 %0d",
                         imem_re, instr_valid, diff, D - 1);
    end
    instr_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 80; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    instr_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_redirect(input logic [PW-1:0] target, input int stall_n);
    instr_ready = 1'b0;
    repeat (stall_n) tick();
    redirect_valid = 1'b1; redirect_pc = target;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    checks++;
    if (instr_valid !== 1'b0 || imem_re !== 1'b1 || imem_addr !== target) begin
      errors++; $display("FAIL redir_r1: got v=%b re=%b addr=%h want 0 1 %h", instr_valid, imem_re, imem_addr, target);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL redir_r2: got valid=%b want 0", instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== target || raw_instruction !== word(target)) begin
      errors++; $display("FAIL redir_r3: got v=%b pc=%h raw=%h want 1 %h %h",
                         instr_valid, instr_pc, raw_instruction, target, word(target));
    end
    repeat (8) tick();
  endtask

  task automatic test_wrap();
    logic [PW-1:0] pc;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    pc = 13'h1FFE;
    start_pc = pc; start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_re !== 1'b1 || imem_addr !== pc) begin
        errors++; $display("FAIL wrap_addr: step %0d got re=%b addr=%h want 1 %h", i, imem_re, imem_addr, pc);
      end
      pc = pc + 1'b1;
      tick();
    end
    repeat (6) tick();
  endtask

  task automatic test_redirect_handshake();
    logic [PW-1:0] target;
    target = PW'($urandom);
    instr_ready = 1'b1;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++; $display("FAIL rh_pre: got valid=%b want 1", instr_valid);
    end
    redirect_valid = 1'b1; redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== target) begin
      errors++; $display("FAIL rh_first: got v=%b pc=%h want 1 %h", instr_valid, instr_pc, target);
    end
    repeat (3) tick();
    stop = 1'b1; redirect_valid = 1'b1; redirect_pc = PW'($urandom);
    tick();
    stop = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (busy !== 1'b0 || instr_valid !== 1'b0 || imem_re !== 1'b0) begin
        errors++; $display("FAIL stop_idle: cycle %0d got busy=%b v=%b re=%b want 0 0 0", i, busy, instr_valid, imem_re);
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    do_start(PW'($urandom), "rs_start");
    repeat (4) tick();
    checks++;
    if (imem_re !== 1'b1) begin
      errors++; $display("FAIL rs_inflight: got re=%b want 1", imem_re);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (imem_re !== 1'b0 || imem_addr !== '0 || busy !== 1'b0 ||
        instr_valid !== 1'b0 || raw_instruction !== '0 || instr_pc !== '0) begin
      errors++; $display("FAIL rs_outputs: got re=%b addr=%h busy=%b v=%b raw=%h pc=%h want all 0",
                         imem_re, imem_addr, busy, instr_valid, raw_instruction, instr_pc);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b0 || imem_re !== 1'b0) begin
        errors++; $display("FAIL rs_quiet: cycle %0d got v=%b re=%b want 0 0", i, instr_valid, imem_re);
      end
    end
    do_start(PW'($urandom), "rs_restart");
    repeat (10) tick();
  endtask

  initial begin
    key = 16'($urandom);
    test_reset();
    test_start_stream();
    test_stall();
    test_redirect(13'h100, 1);
    test_redirect(PW'($urandom), 8);
    test_wrap();
    test_redirect_handshake();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1);
  end

endmodule
